// File: rtl/game_pkg.sv
// Shared types and default constants for the Space Invaders game-flow controller.
// The state encoding is fixed because the HUD decodes it directly.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PLAYING     = 3'd1,
        ST_LIFE_LOST   = 3'd2,
        ST_LEVEL_CLEAR = 3'd3,
        ST_GAME_OVER   = 3'd4,
        ST_PAUSED      = 3'd5
    } state_t;

    localparam int LIVES_INIT_DEF    = 3;
    localparam int LEVELS_DEF        = 4;
    localparam int BANNER_CYCLES_DEF = 50_000_000;
    localparam int OVER_CYCLES_DEF   = 150_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_fsm_edge_detect.sv
// Registered rising-edge detector. RESET_VAL=1 keeps a level held through reset
// from being seen as a fresh press.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) sig_q <= RESET_VAL;
        else       sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/game_flow_fsm.sv
// Game-flow controller: start key and gameplay events -> game state, lives, level.
// Define GAME_PAUSE_EN to add the pause_key input and the PAUSED state.
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LEVELS        = LEVELS_DEF,
    parameter int BANNER_CYCLES = BANNER_CYCLES_DEF,
    parameter int OVER_CYCLES   = OVER_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_key,
    input  logic                      player_hit,
    input  logic                      aliens_cleared,
    input  logic                      aliens_landed,
`ifdef GAME_PAUSE_EN
    input  logic                      pause_key,
`endif
    output logic                      start,
    output logic                      wave_start,
    output logic                      playing,
    output logic [2:0]                state,
    output logic [2:0]                lives,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic                      win
);

    localparam int LW = $clog2(LEVELS);
    localparam int TW = $clog2(max_int(BANNER_CYCLES, OVER_CYCLES) + 1);

    localparam logic [2:0]    LIVES_LOAD  = 3'(LIVES_INIT);
    localparam logic [LW-1:0] LEVEL_LAST  = LW'(LEVELS - 1);
    localparam logic [TW-1:0] BANNER_LAST = TW'(BANNER_CYCLES - 1);
    localparam logic [TW-1:0] OVER_LAST   = TW'(OVER_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      lives_q, lives_d;
    logic [LW-1:0]   level_q, level_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            win_q, win_d;
    logic            start_q, start_d;
    logic            wave_q, wave_d;
    logic            playing_q, playing_d;
    logic            start_rise;

    edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (start_key),
        .rise_o (start_rise)
    );

`ifdef GAME_PAUSE_EN
    logic pause_rise;

    edge_detect #(.RESET_VAL(1'b1)) u_pause_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (pause_key),
        .rise_o (pause_rise)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_LOAD;
            level_q   <= '0;
            timer_q   <= '0;
            win_q     <= 1'b0;
            start_q   <= 1'b0;
            wave_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            timer_q   <= timer_d;
            win_q     <= win_d;
            start_q   <= start_d;
            wave_q    <= wave_d;
            playing_q <= playing_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        win_d   = win_q;
        start_d = 1'b0;
        wave_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_rise) begin
                state_d = ST_PLAYING;
                start_d = 1'b1;
                wave_d  = 1'b1;
                lives_d = LIVES_LOAD;
                level_d = '0;
                win_d   = 1'b0;
            end
            // Event priority: landed > hit > cleared; losers in the same cycle are dropped.
            ST_PLAYING: begin
                if (aliens_landed) begin
                    lives_d = '0;
                    win_d   = 1'b0;
                    state_d = ST_GAME_OVER;
                end else if (player_hit) begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? ST_GAME_OVER : ST_LIFE_LOST;
                end else if (aliens_cleared) begin
                    if (level_q == LEVEL_LAST) begin
                        win_d   = 1'b1;
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_LEVEL_CLEAR;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end
`endif
            end
            ST_LIFE_LOST: if (timer_q == BANNER_LAST) begin
                state_d = ST_PLAYING;
                wave_d  = 1'b1;
            end
            ST_LEVEL_CLEAR: if (timer_q == BANNER_LAST) begin
                level_d = level_q + LW'(1);
                state_d = ST_PLAYING;
                wave_d  = 1'b1;
            end
            ST_GAME_OVER: if (timer_q == OVER_LAST && start_rise) begin
                state_d = ST_IDLE;
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: if (pause_rise) begin
                state_d = ST_PLAYING;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == ST_GAME_OVER) begin
            timer_d = (timer_q == OVER_LAST) ? timer_q : timer_q + TW'(1);
        end else if (state_q == ST_LIFE_LOST || state_q == ST_LEVEL_CLEAR) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end

        playing_d = (state_d == ST_PLAYING);
    end

    always_comb begin
        start      = start_q;
        wave_start = wave_q;
        playing    = playing_q;
        state      = state_q;
        lives      = lives_q;
        level      = level_q;
        win        = win_q;
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm: vector table, directed sequences and
// randomized play checked against a cycle-counting reference model.
module tb_game_flow_fsm;

    localparam int LIVES_INIT = 3;
    localparam int LEVELS     = 4;
    localparam int BANNER     = 8;
    localparam int OVER       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic in_rst = 1'b1, in_key = 1'b1, in_hit = 1'b0, in_clr = 1'b0, in_land = 1'b0;
    logic in_pause = 1'b0;

    logic       start, wave_start, playing, win;
    logic [2:0] state, lives;
    logic [1:0] level;

    game_flow_fsm #(
        .LIVES_INIT    (LIVES_INIT),
        .LEVELS        (LEVELS),
        .BANNER_CYCLES (BANNER),
        .OVER_CYCLES   (OVER)
    ) dut (
        .clk            (clk),
        .reset          (in_rst),
        .start_key      (in_key),
        .player_hit     (in_hit),
        .aliens_cleared (in_clr),
        .aliens_landed  (in_land),
`ifdef GAME_PAUSE_EN
        .pause_key      (in_pause),
`endif
        .start          (start),
        .wave_start     (wave_start),
        .playing        (playing),
        .state          (state),
        .lives          (lives),
        .level          (level),
        .win            (win)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase numbers, cycles spent in the current phase, plain counters.
    int m_state = 0, m_lives = LIVES_INIT, m_level = 0, m_cnt = 0;
    bit m_win = 0, m_start = 0, m_wave = 0, m_key_prev = 1, m_pause_prev = 1;

    task automatic model_step();
        int  nxt;
        int  elapsed;
        bit  rise, prise;
        if (in_rst) begin
            m_state = 0; m_lives = LIVES_INIT; m_level = 0; m_cnt = 0;
            m_win = 0; m_start = 0; m_wave = 0; m_key_prev = 1; m_pause_prev = 1;
            return;
        end
        rise  = in_key && !m_key_prev;
        prise = in_pause && !m_pause_prev;
        m_key_prev   = in_key;
        m_pause_prev = in_pause;
        m_start = 0;
        m_wave  = 0;
        nxt     = m_state;
        elapsed = m_cnt + 1;
        case (m_state)
            0: if (rise) begin
                nxt = 1; m_start = 1; m_wave = 1;
                m_lives = LIVES_INIT; m_level = 0; m_win = 0;
            end
            1: begin
                if (in_land) begin
                    m_lives = 0; m_win = 0; nxt = 4;
                end else if (in_hit) begin
                    m_lives = m_lives - 1;
                    nxt = (m_lives == 0) ? 4 : 2;
                end else if (in_clr) begin
                    if (m_level == LEVELS - 1) begin m_win = 1; nxt = 4; end
                    else nxt = 3;
                end else if (prise) begin
                    nxt = 5;
                end
            end
            2: if (elapsed == BANNER) begin nxt = 1; m_wave = 1; end
            3: if (elapsed == BANNER) begin nxt = 1; m_wave = 1; m_level = m_level + 1; end
            4: if (elapsed >= OVER && rise) nxt = 0;
            5: if (prise) nxt = 1;
            default: nxt = 0;
        endcase
        m_cnt   = (nxt != m_state) ? 0 : m_cnt + 1;
        m_state = nxt;
    endtask

    function automatic logic [11:0] dut_pack();
        return {start, wave_start, playing, state, lives, level, win};
    endfunction

    function automatic logic [11:0] model_pack();
        return {m_start, m_wave, (m_state == 1), 3'(m_state), 3'(m_lives), 2'(m_level), m_win};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (start,wave,playing,state,lives,level,win) at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string name);
        tick();
        check(name, dut_pack(), model_pack());
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            in_hit = 0; in_clr = 0; in_land = 0;
            step_chk(name);
        end
    endtask

    task automatic pulse(input logic h, input logic c, input logic l, input string name);
        in_hit = h; in_clr = c; in_land = l;
        step_chk(name);
        in_hit = 0; in_clr = 0; in_land = 0;
    endtask

    task automatic press(input string name);
        in_key = 0;
        step_chk(name);
        in_key = 1;
        step_chk(name);
    endtask

    typedef struct {
        logic       rst, key, hit, clr, land;
        logic [2:0] st, lv;
        logic [1:0] lvl;
        logic       stp, wav, wn;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1,1,0,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[1]  = '{0,1,0,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[2]  = '{0,0,1,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[3]  = '{0,1,0,0,1, 3'd1,3'd3,2'd0, 1,1,0};
        tbl[4]  = '{0,1,0,0,0, 3'd1,3'd3,2'd0, 0,0,0};
        tbl[5]  = '{0,0,1,0,0, 3'd2,3'd2,2'd0, 0,0,0};
        tbl[6]  = '{0,0,0,1,0, 3'd2,3'd2,2'd0, 0,0,0};
        tbl[7]  = '{1,1,0,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[8]  = '{0,1,0,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[9]  = '{0,0,0,0,0, 3'd0,3'd3,2'd0, 0,0,0};
        tbl[10] = '{0,1,0,0,0, 3'd1,3'd3,2'd0, 1,1,0};

        for (int i = 0; i < 11; i++) begin
            in_rst = tbl[i].rst; in_key = tbl[i].key;
            in_hit = tbl[i].hit; in_clr = tbl[i].clr; in_land = tbl[i].land;
            tick();
            check($sformatf("table[%0d]", i), dut_pack(),
                  {tbl[i].stp, tbl[i].wav, (tbl[i].st == 3'd1), tbl[i].st, tbl[i].lv,
                   tbl[i].lvl, tbl[i].wn});
        end
        in_hit = 0; in_clr = 0; in_land = 0;

        // Key held through reset and for 20 more cycles must not start a game.
        in_rst = 1; in_key = 1;
        step_chk("reset_held");
        in_rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_no_start", {9'd0, start, state}, 12'd0);
        end
        press("first_press");
        check("first_press_state", {start, wave_start, state, lives, 1'b0, level}, {1'b1, 1'b1, 3'd1, 3'd3, 1'b0, 2'd0});

        // Three hits: lives 3 -> 2 -> 1 -> 0.
        pulse(1, 0, 0, "hit1");
        check("hit1_state", {6'd0, state, lives}, {6'd0, 3'd2, 3'd2});
        run(10, "banner1");
        check("banner1_back", {9'd0, state}, 12'd1);
        pulse(1, 0, 0, "hit2");
        check("hit2_state", {6'd0, state, lives}, {6'd0, 3'd2, 3'd1});
        run(10, "banner2");
        pulse(1, 0, 0, "hit3");
        check("hit3_over", {5'd0, state, lives, win}, {5'd0, 3'd4, 3'd0, 1'b0});

        // Early start in GAME_OVER is ignored; later press goes to IDLE, next press starts.
        press("early_press");
        check("early_ignored", {9'd0, state}, 12'd4);
        run(20, "over_wait");
        press("late_press");
        check("late_idle", {8'd0, start, state}, 12'd0);
        press("restart");
        check("restart_start", {8'd0, start, state}, {8'd0, 1'b1, 3'd1});

        // Clear all waves to win.
        for (int i = 0; i < LEVELS - 1; i++) begin
            pulse(0, 1, 0, "clear");
            check("clear_state", {9'd0, state}, 12'd3);
            run(10, "clear_banner");
            check("clear_level", {7'd0, state, level}, {7'd0, 3'd1, 2'(i + 1)});
        end
        pulse(0, 1, 0, "clear_last");
        check("win_over", {5'd0, state, lives, win}, {5'd0, 3'd4, 3'd3, 1'b1});
        run(20, "win_wait");
        press("win_to_idle");
        press("win_restart");
        check("win_restart_state", {8'd0, start, state}, {8'd0, 1'b1, 3'd1});

        // Simultaneous events resolve by priority.
        pulse(1, 0, 0, "prio_hit");
        run(10, "prio_banner");
        pulse(1, 1, 0, "hit_and_clear");
        check("hit_beats_clear", {4'd0, state, lives, level}, {4'd0, 3'd2, 3'd1, 2'd0});
        run(10, "prio_banner2");
        pulse(1, 0, 1, "land_and_hit");
        check("land_beats_hit", {5'd0, state, lives, win}, {5'd0, 3'd4, 3'd0, 1'b0});

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            in_rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) in_key = ~in_key;
            in_hit  = ($urandom_range(0, 19) == 0);
            in_clr  = ($urandom_range(0, 19) == 0);
            in_land = ($urandom_range(0, 59) == 0);
`ifdef GAME_PAUSE_EN
            if ($urandom_range(0, 15) == 0) in_pause = ~in_pause;
`endif
            step_chk("random");
        end
        in_rst = 0; in_hit = 0; in_clr = 0; in_land = 0;

`ifdef GAME_PAUSE_EN
        in_rst = 1; in_pause = 0;
        step_chk("pause_reset");
        in_rst = 0;
        press("pause_start");
        in_pause = 1;
        step_chk("pause_on");
        check("paused", {8'd0, playing, state}, {8'd0, 1'b0, 3'd5});
        pulse(1, 0, 0, "paused_hit");
        check("paused_hit_ignored", {6'd0, state, lives}, {6'd0, 3'd5, 3'd3});
        in_pause = 0;
        step_chk("pause_rel");
        in_pause = 1;
        step_chk("pause_off");
        check("resumed", {7'd0, wave_start, playing, state}, {7'd0, 1'b0, 1'b1, 3'd1});
        in_pause = 0;
        step_chk("pause_rel2");
        in_pause = 1;
        step_chk("pause_on2");
        in_rst = 1;
        step_chk("reset_in_pause");
        check("reset_in_pause_idle", {9'd0, state}, 12'd0);
        in_rst = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
